multicycle_ctrl: RTL

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, instruction/data memory port, register file and PC over several cycles per instruction. Each cycle it drives the datapath mux selects, the write enables and the 2-bit ALUOp consumed by the ALU decoder. It waits on a one-bit memory ready handshake and traps on unsupported opcodes.

---
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core. It sequences the shared ALU,
// the memory port, the register file and the PC. Most outputs are Moore
// functions of the state. PCWrite also depends on Zero, the FETCH strobes are
// gated by MemReady, and ImmSrc is decoded from op.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] state
);

  localparam logic [3:0] Fetch    = 4'd0;
  localparam logic [3:0] Decode   = 4'd1;
  localparam logic [3:0] MemAdr   = 4'd2;
  localparam logic [3:0] MemRead  = 4'd3;
  localparam logic [3:0] MemWb    = 4'd4;
  localparam logic [3:0] MemWr    = 4'd5;
  localparam logic [3:0] ExecuteR = 4'd6;
  localparam logic [3:0] ExecuteI = 4'd7;
  localparam logic [3:0] AluWb    = 4'd8;
  localparam logic [3:0] Beq      = 4'd9;
  localparam logic [3:0] Jal      = 4'd10;
  localparam logic [3:0] Trap     = 4'd15;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic       pc_update;
  logic       branch;

  // Next-state selection; unused encodings and unknown opcodes fall into Trap.
  always_comb begin
    state_d = Trap;
    unique case (state_q)
      Fetch:    state_d = MemReady ? Decode : Fetch;
      Decode: begin
        unique case (op)
          OpLoad, OpStore: state_d = MemAdr;
          OpRType:         state_d = ExecuteR;
          OpIType:         state_d = ExecuteI;
          OpBranch:        state_d = Beq;
          OpJal:           state_d = Jal;
          default:         state_d = Trap;
        endcase
      end
      MemAdr:   state_d = op[5] ? MemWr : MemRead;
      MemRead:  state_d = MemReady ? MemWb : MemRead;
      MemWb:    state_d = Fetch;
      MemWr:    state_d = MemReady ? Fetch : MemWr;
      ExecuteR: state_d = AluWb;
      ExecuteI: state_d = AluWb;
      AluWb:    state_d = Fetch;
      Beq:      state_d = Fetch;
      Jal:      state_d = AluWb;
      default:  state_d = Trap;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath controls per state; anything not set for a state stays 0.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    Illegal   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    unique case (state_q)
      Fetch: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pc_update = MemReady;
      end
      Decode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MemRead: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MemWr: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      ExecuteR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      ExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      AluWb: RegWrite = 1'b1;
      Beq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      Jal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      Trap:    Illegal = 1'b1;
      default: ;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    unique case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign state   = state_q;

endmodule
